// File: rtl/pll_lock_sequencer.sv
// Power-up / relock sequencer for the fabric PLL, clocked from the free-running reference.
// Times the power-down pulse, qualifies lock, retries on timeout and holds the PLL-domain reset.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | disabled; PLL held in power-down, domain reset asserted
// POWERDOWN  | power-down pulse being timed
// WAIT_LOCK  | PLL running, waiting for synchronised lock (timeout -> retry)
// STABLE     | lock seen, checking it stays high for the stable window
// RUN        | locked and stable; READY high, domain reset released
// FAULT      | retries exhausted; PLL parked in power-down until disabled
module pll_lock_sequencer #(
  parameter int POWERDOWN_CYCLES   = 64,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 3,
  parameter int CNT_W              = 17
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       RELOCK_REQ,
  input  logic       PLL_LOCK,
  output logic       PLL_POWERDOWN_N,
  output logic       READY,
  output logic       RESET_OUT,
  output logic       FAULT,
  output logic [2:0] STATE,
  output logic [1:0] RETRY_CNT,
  output logic [7:0] LOCK_LOSS_CNT
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POWERDOWN = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] PD_LAST     = CNT_W'(POWERDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

  logic             lock_meta;
  logic             lock_s;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       retry_q;
  logic [1:0]       retry_d;
  logic [1:0]       retry_inc;
  logic [7:0]       loss_q;
  logic [7:0]       loss_d;
  logic             pd_n_q;
  logic             pd_n_d;
  logic             ready_q;
  logic             ready_d;
  logic             reset_out_q;
  logic             reset_out_d;
  logic             fault_q;
  logic             fault_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      lock_meta   <= 1'b0;
      lock_s      <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      retry_q     <= 2'd0;
      loss_q      <= 8'd0;
      pd_n_q      <= 1'b0;
      ready_q     <= 1'b0;
      reset_out_q <= 1'b1;
      fault_q     <= 1'b0;
    end else begin
      lock_meta   <= PLL_LOCK;
      lock_s      <= lock_meta;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pd_n_q      <= pd_n_d;
      ready_q     <= ready_d;
      reset_out_q <= reset_out_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    loss_d    = loss_q;
    retry_inc = retry_q + 2'd1;

    if (!ENABLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = ST_POWERDOWN;
        ST_POWERDOWN: if (cnt_q == PD_LAST) state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          // lock wins over a timeout landing on the same cycle
          if (lock_s) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_POWERDOWN;
          end
        end
        ST_STABLE: begin
          if (!lock_s) state_d = ST_WAIT_LOCK;
          else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!lock_s || RELOCK_REQ) begin
            state_d = ST_POWERDOWN;
            if (!lock_s && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_IDLE;
      endcase
    end

    // counter only times POWERDOWN, WAIT_LOCK and STABLE; parked at zero elsewhere
    if (state_d != state_q || state_q == ST_IDLE || state_q == ST_RUN || state_q == ST_FAULT)
      cnt_d = '0;
    else
      cnt_d = cnt_q + CNT_ONE;

    if (state_d == ST_IDLE || state_d == ST_RUN) retry_d = 2'd0;

    pd_n_d      = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) || (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
    reset_out_d = (state_d != ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  assign PLL_POWERDOWN_N = pd_n_q;
  assign READY           = ready_q;
  assign RESET_OUT       = reset_out_q;
  assign FAULT           = fault_q;
  assign STATE           = state_q;
  assign RETRY_CNT       = retry_q;
  assign LOCK_LOSS_CNT   = loss_q;

endmodule
